// File: rtl/pid_pkg.sv
// pid_pkg: shared definitions for the pid_scheduler slice.
//   - state_t      : scheduler FSM states
//   - CFG_*        : config bus addresses
//   - GAIN_*       : core gain register indices
//   - sat_clamp()  : signed clamp used when publishing results
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_TICK,
        ISSUE,
        BUSY,
        PUBLISH
    } state_t;

    localparam logic [2:0] CFG_KP     = 3'd0;
    localparam logic [2:0] CFG_KI     = 3'd1;
    localparam logic [2:0] CFG_KD1    = 3'd2;
    localparam logic [2:0] CFG_KD2    = 3'd3;
    localparam logic [2:0] CFG_PERIOD = 3'd4;
    localparam logic [2:0] CFG_COMMIT = 3'd5;
    localparam logic [2:0] CFG_CLR    = 3'd6;

    localparam logic [1:0] GAIN_KP  = 2'd0;
    localparam logic [1:0] GAIN_KI  = 2'd1;
    localparam logic [1:0] GAIN_KD1 = 2'd2;
    localparam logic [1:0] GAIN_KD2 = 2'd3;

    // Operates on sign-extended 32-bit values so it is independent of D_WIDTH.
    function automatic int sat_clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pid_scheduler_if.sv
// pid_scheduler_if: control/result bundle between the scheduler and one pid core.
//   master (scheduler): drives core_cfg_we, core_reg_addr, core_reg_data,
//                       core_iterate, core_target, core_measurement;
//                       receives core_out, core_out_valid.
//   slave  (core)     : the reverse.
interface pid_scheduler_if #(
    parameter int D_WIDTH = 16
);
    logic               core_cfg_we;
    logic [D_WIDTH-1:0] core_reg_addr;
    logic [D_WIDTH-1:0] core_reg_data;
    logic               core_iterate;
    logic [D_WIDTH-1:0] core_target;
    logic [D_WIDTH-1:0] core_measurement;
    logic [D_WIDTH-1:0] core_out;
    logic               core_out_valid;

    modport master (
        output core_cfg_we, core_reg_addr, core_reg_data, core_iterate,
               core_target, core_measurement,
        input  core_out, core_out_valid
    );

    modport slave (
        input  core_cfg_we, core_reg_addr, core_reg_data, core_iterate,
               core_target, core_measurement,
        output core_out, core_out_valid
    );
endinterface

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: programmable sample timer.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : run; when low the counter is held at its reload value
//   period_we     : write strobe for the period register
//   period_wdata  : new period (cycles); values below MIN_PERIOD act as MIN_PERIOD
//   tick          : one-cycle pulse every effective-period cycles
// A period write only changes the reload value, so it takes effect at the
// next reload rather than truncating the interval in flight.
module pid_tick_gen #(
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                period_we,
    input  logic [PERIOD_W-1:0] period_wdata,
    output logic                tick
);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] eff;
    logic [PERIOD_W-1:0] cnt;

    assign eff  = (period < MIN_P) ? MIN_P : period;
    assign tick = enable && (cnt == '0);

    // Counting eff-1 .. 0 gives exactly one tick every eff cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= MIN_P;
            cnt    <= MIN_P - PERIOD_W'(1);
        end else begin
            if (period_we)
                period <= period_wdata;
            if (!enable || cnt == '0)
                cnt <= eff - PERIOD_W'(1);
            else
                cnt <= cnt - PERIOD_W'(1);
        end
    end
endmodule

// File: rtl/pid_scheduler.sv
// pid_scheduler: sequencing controller for a single pid core.
//   clk, rst             : clock, synchronous active-high reset
//   enable               : run request
//   cfg_we/addr/wdata    : host config bus (shadow gains, period, commit, clear)
//   target, measurement  : live setpoint and plant value (snapshotted on tick)
//   core                 : pid_scheduler_if.master to the core
//   ctrl_out, ctrl_valid : published result (held) and its one-cycle strobe
//   busy                 : FSM outside IDLE
//   overrun, timeout_err, sat : sticky status, cleared by a CFG_CLR write
// Build option: define PID_SCHED_SAT_EN to clamp published results to
// [LIM_MIN, LIM_MAX] and report clamping on sat; otherwise results pass
// through unchanged and sat stays 0.
module pid_scheduler
    import pid_pkg::*;
#(
    parameter int D_WIDTH    = 16,
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 8,
    parameter int TIMEOUT    = 32,
    parameter int LIM_MAX    = 1 <<< 12,
    parameter int LIM_MIN    = -(1 <<< 12)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [D_WIDTH-1:0]   cfg_wdata,
    input  logic [D_WIDTH-1:0]   target,
    input  logic [D_WIDTH-1:0]   measurement,
    pid_scheduler_if.master      core,
    output logic [D_WIDTH-1:0]   ctrl_out,
    output logic                 ctrl_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic                 sat
);
`ifdef PID_SCHED_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t                    state, state_nx;
    logic [1:0]                lcnt;
    logic [WCNT_W-1:0]         wcnt;
    logic                      commit_pending;
    logic [3:0][D_WIDTH-1:0]   shadow;
    logic                      tick;
    logic                      sat_q;
    logic                      clr;
    logic                      timed_out;

    logic signed [D_WIDTH-1:0] core_out_s;
    int                        res_ext;
    int                        res_clamped;
    logic                      clamp_hit;
    logic [D_WIDTH-1:0]        result;

    pid_tick_gen #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period_we    (cfg_we && cfg_addr == CFG_PERIOD),
        .period_wdata (cfg_wdata[PERIOD_W-1:0]),
        .tick         (tick)
    );

    // Result path: clamp is computed unconditionally, the build option picks it.
    assign core_out_s  = core.core_out;
    assign res_ext     = int'(core_out_s);
    assign res_clamped = sat_clamp(res_ext, LIM_MIN, LIM_MAX);
    assign clamp_hit   = SAT_EN && (res_clamped != res_ext);
    assign result      = SAT_EN ? res_clamped[D_WIDTH-1:0] : core.core_out;
    assign sat         = SAT_EN ? sat_q : 1'b0;

    assign busy      = (state != IDLE);
    assign clr       = cfg_we && (cfg_addr == CFG_CLR);
    assign timed_out = (state == BUSY) && !core.core_out_valid
                       && (wcnt == WCNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx           = state;
        core.core_cfg_we   = 1'b0;
        core.core_reg_addr = '0;
        core.core_reg_data = '0;
        core.core_iterate  = 1'b0;
        case (state)
            IDLE:
                if (enable) state_nx = commit_pending ? LOAD : WAIT_TICK;
            LOAD: begin
                core.core_cfg_we   = 1'b1;
                core.core_reg_addr = D_WIDTH'(lcnt);
                core.core_reg_data = shadow[lcnt];
                if (lcnt == 2'd3) state_nx = WAIT_TICK;
            end
            WAIT_TICK:
                // A tick beats a pending commit; the commit runs next gap.
                if (!enable)             state_nx = IDLE;
                else if (tick)           state_nx = ISSUE;
                else if (commit_pending) state_nx = LOAD;
            ISSUE: begin
                core.core_iterate = 1'b1;
                state_nx          = BUSY;
            end
            BUSY:
                if (core.core_out_valid) state_nx = PUBLISH;
                else if (timed_out)      state_nx = enable ? WAIT_TICK : IDLE;
            PUBLISH:
                state_nx = enable ? WAIT_TICK : IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            lcnt                  <= '0;
            wcnt                  <= '0;
            commit_pending        <= 1'b1;
            shadow                <= '0;
            core.core_target      <= '0;
            core.core_measurement <= '0;
            ctrl_out              <= '0;
            ctrl_valid            <= 1'b0;
            overrun               <= 1'b0;
            timeout_err           <= 1'b0;
            sat_q                 <= 1'b0;
        end else begin
            state      <= state_nx;
            ctrl_valid <= 1'b0;
            lcnt       <= (state == LOAD) ? lcnt + 2'd1 : 2'd0;
            wcnt       <= (state == BUSY) ? wcnt + WCNT_W'(1) : '0;

            if (cfg_we) begin
                case (cfg_addr)
                    CFG_KP:  shadow[GAIN_KP]  <= cfg_wdata;
                    CFG_KI:  shadow[GAIN_KI]  <= cfg_wdata;
                    CFG_KD1: shadow[GAIN_KD1] <= cfg_wdata;
                    CFG_KD2: shadow[GAIN_KD2] <= cfg_wdata;
                    default: ;
                endcase
            end

            // Later assignment wins: a commit write during the last LOAD
            // cycle keeps the flag set so the new gains are not lost.
            if (state == LOAD && lcnt == 2'd3) commit_pending <= 1'b0;
            if (cfg_we && cfg_addr == CFG_COMMIT) commit_pending <= 1'b1;

            if (state == WAIT_TICK && tick) begin
                core.core_target      <= target;
                core.core_measurement <= measurement;
            end

            if (state == BUSY && core.core_out_valid) begin
                ctrl_out   <= result;
                ctrl_valid <= 1'b1;
            end

            // Clear first, then set, so a same-cycle event survives the clear.
            if (clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
                sat_q       <= 1'b0;
            end
            if (tick && state != WAIT_TICK)                    overrun     <= 1'b1;
            if (timed_out)                                     timeout_err <= 1'b1;
            if (state == BUSY && core.core_out_valid && clamp_hit) sat_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler: directed bench for pid_scheduler with a behavioural core
// model (programmable reply latency, 0 = never replies). Cycle indices nc
// count negedges from the moment enable is first raised.
module tb_pid_scheduler;
    import pid_pkg::*;

`ifdef PID_SCHED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] target;
    logic [15:0] measurement;
    logic [15:0] ctrl_out;
    logic        ctrl_valid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic        sat;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          nc     = 0;
    int          lat    = 5;
    int          m_cnt  = 0;
    int          extra;
    logic [15:0] m_val  = 16'h0123;
    logic [15:0] exp_g [4];

    pid_scheduler_if #(.D_WIDTH(16)) core_bus ();

    pid_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .target      (target),
        .measurement (measurement),
        .core        (core_bus),
        .ctrl_out    (ctrl_out),
        .ctrl_valid  (ctrl_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    // Core model: iterate seen at the end of cycle I -> valid during I+lat.
    always @(posedge clk) begin
        if (rst)                               m_cnt <= 0;
        else if (core_bus.core_iterate && lat > 0) m_cnt <= lat;
        else if (m_cnt > 0)                    m_cnt <= m_cnt - 1;
    end
    assign core_bus.core_out_valid = (m_cnt == 1);
    assign core_bus.core_out       = m_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (nc < n) begin
            @(negedge clk);
            nc++;
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        nc++;
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        target = 16'h0100; measurement = 16'h0040;
        exp_g[0] = 16'h2000; exp_g[1] = 16'h0400; exp_g[2] = 16'h0000; exp_g[3] = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ctrl_out",  ctrl_out, 0);
        chk("rst_ctrl_vld",  ctrl_valid, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_cfg_we",    core_bus.core_cfg_we, 0);
        chk("rst_iterate",   core_bus.core_iterate, 0);
        chk("rst_target",    core_bus.core_target, 0);
        chk("rst_flags",     {overrun, timeout_err, sat}, 0);

        // Gain commit and run, period 20
        cfg_write(CFG_KP, 16'h2000);
        cfg_write(CFG_KI, 16'h0400);
        cfg_write(CFG_PERIOD, 16'd20);
        cfg_write(CFG_COMMIT, 16'h0000);
        repeat (2) @(negedge clk);
        nc = 0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            goto(i + 1);
            chk("load_we",   core_bus.core_cfg_we, 1);
            chk("load_addr", core_bus.core_reg_addr, i);
            chk("load_data", core_bus.core_reg_data, exp_g[i]);
        end
        goto(5);
        chk("load_done_we", core_bus.core_cfg_we, 0);
        chk("busy_wait",    busy, 1);

        // Latency: tick at 19, iterate 20, reply 25, publish 26
        goto(19); chk("iter_pre",  core_bus.core_iterate, 0);
        goto(20); chk("iter_t1",   core_bus.core_iterate, 1);
        chk("snap_target", core_bus.core_target, 16'h0100);
        chk("snap_meas",   core_bus.core_measurement, 16'h0040);
        goto(21); chk("iter_pulse", core_bus.core_iterate, 0);
        goto(25); chk("vld_early", ctrl_valid, 0);
        goto(26); chk("vld_t7",    ctrl_valid, 1);
        chk("out_t7", ctrl_out, 16'h0123);
        goto(27); chk("vld_pulse", ctrl_valid, 0);
        chk("out_hold", ctrl_out, 16'h0123);
        goto(30); target = 16'h0200;
        goto(35); chk("snap_hold", core_bus.core_target, 16'h0100);
        goto(39); chk("iter_gap",  core_bus.core_iterate, 0);
        goto(40); chk("iter_p20",  core_bus.core_iterate, 1);
        chk("snap_new", core_bus.core_target, 16'h0200);

        // Timeout: period 40 from the reload at 59, core silent from then on
        goto(41); lat = 0; m_val = 16'h0456;
        cfg_write(CFG_PERIOD, 16'd40);
        goto(46); chk("vld_2", ctrl_valid, 1);
        chk("out_2", ctrl_out, 16'h0456);
        goto(60); chk("iter_to", core_bus.core_iterate, 1);
        goto(92); chk("to_early", timeout_err, 0);
        chk("to_busy", busy, 1);
        goto(93); chk("to_set", timeout_err, 1);
        chk("to_hold_out", ctrl_out, 16'h0456);
        chk("to_no_vld",   ctrl_valid, 0);
        chk("to_no_ovr",   overrun, 0);

        // Saturation value, latency 12, then period 8 for overrun
        goto(99); lat = 12; m_val = 16'h1800;
        goto(100); chk("iter_after_to", core_bus.core_iterate, 1);
        goto(101); cfg_write(CFG_PERIOD, 16'd8);
        goto(113); chk("sat_vld", ctrl_valid, 1);
        chk("sat_out_pos", ctrl_out, SAT ? 16'h1000 : 16'h1800);
        chk("sat_flag",    sat, SAT ? 1 : 0);
        goto(114); m_val = 16'hE000;
        goto(140); chk("iter_ovr", core_bus.core_iterate, 1);
        chk("to_sticky", timeout_err, 1);
        extra = 0;
        while (nc < 155) begin
            @(negedge clk);
            nc++;
            if (core_bus.core_iterate) extra++;
            if (nc == 147) chk("ovr_early", overrun, 0);
            if (nc == 148) chk("ovr_set", overrun, 1);
            if (nc == 153) chk("sat_out_neg", ctrl_out, SAT ? 16'hF000 : 16'hE000);
        end
        chk("ovr_dropped", extra, 0);
        goto(156); chk("iter_next", core_bus.core_iterate, 1);
        goto(157); cfg_write(CFG_CLR, 16'h0000);
        chk("clr_flags", {overrun, timeout_err, sat}, 0);

        // Enable dropped in BUSY: publish completes, then IDLE
        goto(160); enable = 1'b0;
        goto(169); chk("dis_vld", ctrl_valid, 1);
        chk("dis_busy", busy, 1);
        goto(170); chk("dis_idle", busy, 0);
        chk("dis_no_ovr", overrun, 0);
        chk("dis_sat", sat, SAT ? 1 : 0);

        // Reset in BUSY
        goto(171); enable = 1'b1;
        goto(179); chk("iter_re", core_bus.core_iterate, 1);
        goto(182); chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        goto(183);
        chk("rb_ctrl_out", ctrl_out, 0);
        chk("rb_vld",      ctrl_valid, 0);
        chk("rb_busy",     busy, 0);
        chk("rb_iter",     core_bus.core_iterate, 0);
        chk("rb_target",   core_bus.core_target, 0);
        chk("rb_meas",     core_bus.core_measurement, 0);
        chk("rb_flags",    {overrun, timeout_err, sat}, 0);
        rst = 1'b0;
        enable = 1'b0;
        goto(185);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
